disp_mixer: RTL and testbench

- Parametrised successor to the fixed three-layer me/bullet/enemy display-and-crash path.
- Merges LAYERS sprite layers (rgb plus alpha) into one VGA pixel through a registered priority pipeline.
- Detects per-pair pixel overlap (collision) and reports a per-cycle pulse plus per-frame sticky flags latched at each frame boundary.
- Sits between the sprite blocks and the VGA output stage in the clk_vga domain; replaces the ad-hoc alpha/crash logic of the current game control.

---
 rtl/disp_mixer_pkg.sv | 18 +
 rtl/disp_mixer_pair_collide.sv | 106 ++++++++++
 rtl/disp_mixer.sv | 120 ++++++++++++
 tb/tb_disp_mixer.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_mixer_pkg.sv
// Shared definitions for the display mixer.
//   COLOR_RGB_DEPTH : default colour depth of one VGA pixel.
//   HIT_CNT_W       : width of each per-pair collision counter.
//   pair_idx(i,j,n) : bit position of layer pair (i,j), i<j, among n layers.
//                     Pairs are enumerated lexicographically:
//                     (0,1),(0,2),...,(0,n-1),(1,2),...
package disp_mixer_pkg;

  localparam int COLOR_RGB_DEPTH = 12;
  localparam int HIT_CNT_W       = 8;

  // Layer i owns a block of (n-1-i) pairs. The blocks for rows 0..i-1 hold
  // i*n - i*(i+1)/2 pairs in total; (i,j) sits j-i-1 entries into row i.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/disp_mixer_pair_collide.sv
// Pair collision detector for the display mixer.
// Takes the stage-1 alpha vector, ANDs every layer pair into a registered
// per-pixel pulse and keeps a sticky per-frame record of those pulses.
// Ports:
//   clk_vga        pixel clock
//   rst            asynchronous active-low reset
//   alpha_p1_i     stage-1 alpha, already masked by the display window
//   frame_bdy_i    one-cycle frame boundary (v_sync falling edge)
//   crash_pulse_o  per-pair overlap, registered at stage 2
//   crash_frame_o  OR of crash_pulse_o over the previous complete frame
//   frame_tick_o   one-cycle pulse when crash_frame_o updates
//   hit_cnt_o      per-pair colliding-pixel count of the previous frame
//                  (present only when DISP_MIXER_HIT_CNT_EN is defined)
module disp_mixer_pair_collide
  import disp_mixer_pkg::*;
#(
  parameter  int LAYERS = 3,
  localparam int NPAIRS = LAYERS * (LAYERS - 1) / 2
) (
  input  logic                             clk_vga,
  input  logic                             rst,
  input  logic [LAYERS-1:0]                alpha_p1_i,
  input  logic                             frame_bdy_i,
  output logic [NPAIRS-1:0]                crash_pulse_o,
  output logic [NPAIRS-1:0]                crash_frame_o,
  output logic                             frame_tick_o
`ifdef DISP_MIXER_HIT_CNT_EN
  ,
  output logic [NPAIRS*HIT_CNT_W-1:0]      hit_cnt_o
`endif
);

  logic [NPAIRS-1:0] pulse_d, pulse_q;
  logic [NPAIRS-1:0] acc_d, acc_q;
  logic [NPAIRS-1:0] frame_d, frame_q;
  logic              tick_q;

  for (genvar i = 0; i < LAYERS; i++) begin : g_row
    for (genvar j = i + 1; j < LAYERS; j++) begin : g_col
      assign pulse_d[pair_idx(i, j, LAYERS)] = alpha_p1_i[i] & alpha_p1_i[j];
    end
  end

  // A pulse visible on the boundary cycle still belongs to the closing frame,
  // so it is folded into the published value and not into the new accumulator.
  always_comb begin
    acc_d   = acc_q | pulse_q;
    frame_d = frame_q;
    if (frame_bdy_i) begin
      frame_d = acc_q | pulse_q;
      acc_d   = '0;
    end
  end

  // ---- stage 2: pair pulse, sticky accumulator, frame publish ----
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      pulse_q <= '0;
      acc_q   <= '0;
      frame_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
      tick_q  <= frame_bdy_i;
    end
  end

  assign crash_pulse_o = pulse_q;
  assign crash_frame_o = frame_q;
  assign frame_tick_o  = tick_q;

`ifdef DISP_MIXER_HIT_CNT_EN
  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] c,
                                                   input logic                 inc);
    return (inc && (c != '1)) ? c + 1'b1 : c;
  endfunction

  for (genvar p = 0; p < NPAIRS; p++) begin : g_hit
    logic [HIT_CNT_W-1:0] cnt_d, cnt_q, hit_d, hit_q;

    always_comb begin
      cnt_d = sat_inc(cnt_q, pulse_q[p]);
      hit_d = hit_q;
      if (frame_bdy_i) begin
        hit_d = cnt_d;
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk_vga or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        hit_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        hit_q <= hit_d;
      end
    end

    assign hit_cnt_o[p*HIT_CNT_W +: HIT_CNT_W] = hit_q;
  end
`endif

endmodule

// File: rtl/disp_mixer.sv
// Display mixer: merges LAYERS sprite layers into one VGA pixel through a
// two-stage registered priority pipeline (layer 0 wins) and reports layer
// pair collisions per pixel and per frame.
// Optional feature macro: DISP_MIXER_HIT_CNT_EN adds hit_cnt_o.
// Ports:
//   clk_vga        pixel clock
//   rst            asynchronous active-low reset
//   en_i           display-active window
//   v_sync_i       VGA vertical sync, active-low (frame boundary on its fall)
//   layer_rgb_i    layer k colour at [k*RGB_W +: RGB_W]
//   layer_alpha_i  layer k opaque at this pixel
//   vga_rgb_o      merged pixel, 2 cycles after input
//   disp_o         en_i aligned with vga_rgb_o
//   crash_pulse_o  per-pair overlap aligned with vga_rgb_o
//   crash_frame_o  per-pair overlap seen during the previous frame
//   frame_tick_o   one-cycle pulse when crash_frame_o updates
//   hit_cnt_o      per-pair colliding-pixel counts (DISP_MIXER_HIT_CNT_EN)
module disp_mixer
  import disp_mixer_pkg::*;
#(
  parameter  int               LAYERS = 3,
  parameter  int               RGB_W  = COLOR_RGB_DEPTH,
  parameter  logic [RGB_W-1:0] BG_RGB = 12'h000,
  localparam int               NPAIRS = LAYERS * (LAYERS - 1) / 2
) (
  input  logic                        clk_vga,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic                        v_sync_i,
  input  logic [LAYERS*RGB_W-1:0]     layer_rgb_i,
  input  logic [LAYERS-1:0]           layer_alpha_i,
  output logic [RGB_W-1:0]            vga_rgb_o,
  output logic                        disp_o,
  output logic [NPAIRS-1:0]           crash_pulse_o,
  output logic [NPAIRS-1:0]           crash_frame_o,
  output logic                        frame_tick_o
`ifdef DISP_MIXER_HIT_CNT_EN
  ,
  output logic [NPAIRS*HIT_CNT_W-1:0] hit_cnt_o
`endif
);

  logic [LAYERS*RGB_W-1:0] rgb_p1_q;
  logic [LAYERS-1:0]       alpha_p1_d, alpha_p1_q;
  logic                    en_p1_q;
  logic [RGB_W-1:0]        rgb_p2_d, rgb_p2_q;
  logic                    disp_p2_q;
  logic                    v_sync_q;
  logic                    frame_bdy;
  logic [RGB_W-1:0]        chain [LAYERS+1];

  // Alpha is gated by the window here so neither the priority select nor the
  // collision logic can see an opaque layer during blanking.
  assign alpha_p1_d = layer_alpha_i & {LAYERS{en_i}};

  // ---- stage 1: input capture ----
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      rgb_p1_q   <= '0;
      alpha_p1_q <= '0;
      en_p1_q    <= 1'b0;
    end else begin
      rgb_p1_q   <= layer_rgb_i;
      alpha_p1_q <= alpha_p1_d;
      en_p1_q    <= en_i;
    end
  end

  // Priority chain from the lowest-priority end: each layer overrides what
  // lies behind it, so chain[0] holds the lowest-index opaque layer. The tail
  // is the background inside the window and black during blanking.
  assign chain[LAYERS] = en_p1_q ? BG_RGB : '0;
  for (genvar k = 0; k < LAYERS; k++) begin : g_prio
    assign chain[k] = alpha_p1_q[k] ? rgb_p1_q[k*RGB_W +: RGB_W] : chain[k+1];
  end
  assign rgb_p2_d = chain[0];

  // ---- stage 2: merged pixel ----
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      rgb_p2_q  <= '0;
      disp_p2_q <= 1'b0;
    end else begin
      rgb_p2_q  <= rgb_p2_d;
      disp_p2_q <= en_p1_q;
    end
  end

  // Raw v_sync is compared against its one-cycle-old copy; it does not travel
  // with the pixel pipeline.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      v_sync_q <= 1'b1;
    end else begin
      v_sync_q <= v_sync_i;
    end
  end

  assign frame_bdy = v_sync_q & ~v_sync_i;

  disp_mixer_pair_collide #(
    .LAYERS (LAYERS)
  ) u_collide (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .alpha_p1_i    (alpha_p1_q),
    .frame_bdy_i   (frame_bdy),
    .crash_pulse_o (crash_pulse_o),
    .crash_frame_o (crash_frame_o),
    .frame_tick_o  (frame_tick_o)
`ifdef DISP_MIXER_HIT_CNT_EN
    ,
    .hit_cnt_o     (hit_cnt_o)
`endif
  );

  assign vga_rgb_o = rgb_p2_q;
  assign disp_o    = disp_p2_q;

endmodule

// File: tb/tb_disp_mixer.sv
module tb_disp_mixer;

  localparam int          L  = 3;
  localparam int          W  = 12;
  localparam int          NP = 3;
  localparam logic [W-1:0] BG = 12'h000;

  logic            clk_vga = 1'b0;
  logic            rst;
  logic            en_i;
  logic            v_sync_i;
  logic [L*W-1:0]  layer_rgb_i;
  logic [L-1:0]    layer_alpha_i;
  logic [W-1:0]    vga_rgb_o;
  logic            disp_o;
  logic [NP-1:0]   crash_pulse_o;
  logic [NP-1:0]   crash_frame_o;
  logic            frame_tick_o;
`ifdef DISP_MIXER_HIT_CNT_EN
  logic [NP*8-1:0] hit_cnt_o;
`endif

  disp_mixer #(
    .LAYERS (L),
    .RGB_W  (W),
    .BG_RGB (BG)
  ) dut (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .en_i          (en_i),
    .v_sync_i      (v_sync_i),
    .layer_rgb_i   (layer_rgb_i),
    .layer_alpha_i (layer_alpha_i),
    .vga_rgb_o     (vga_rgb_o),
    .disp_o        (disp_o),
    .crash_pulse_o (crash_pulse_o),
    .crash_frame_o (crash_frame_o),
    .frame_tick_o  (frame_tick_o)
`ifdef DISP_MIXER_HIT_CNT_EN
    ,
    .hit_cnt_o     (hit_cnt_o)
`endif
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct packed {
    logic [W-1:0]  rgb;
    logic          disp;
    logic [NP-1:0] pulse;
  } exp_t;

  typedef struct packed {
    logic          en;
    logic [L-1:0]  a;
    logic [L*W-1:0] rgb;
    logic          vs;
  } stim_t;

  exp_t          sb[$];
  exp_t          cur_exp;
  logic          m_vq;
  logic [NP-1:0] m_acc;
  logic [NP-1:0] exp_frame;
  logic          exp_tick;
  int            nvec = 0;
  int            nerr = 0;

  // Reference pixel model: first opaque layer in ascending order wins.
  function automatic exp_t model(input logic en, input logic [L-1:0] a,
                                 input logic [L*W-1:0] rgb);
    exp_t           e;
    logic [L-1:0]   at;
    logic [L*W-1:0] rt;
    logic [NP-1:0]  bit_p;
    logic           found, ai;
    e = '0;
    e.disp = en;
    found = 1'b0;
    for (int k = 0; k < L; k++) begin
      at = a >> k;
      rt = rgb >> (k * W);
      if (en && at[0] && !found) begin
        e.rgb = rt[W-1:0];
        found = 1'b1;
      end
    end
    if (en && !found) e.rgb = BG;
    bit_p = '0;
    bit_p[0] = 1'b1;
    for (int i = 0; i < L; i++) begin
      for (int j = i + 1; j < L; j++) begin
        at = a >> i;
        ai = at[0];
        at = a >> j;
        if (en && ai && at[0]) e.pulse = e.pulse | bit_p;
        bit_p = bit_p << 1;
      end
    end
    return e;
  endfunction

  function automatic logic [W+2*NP+1:0] obs();
    return {vga_rgb_o, disp_o, crash_pulse_o, crash_frame_o, frame_tick_o};
  endfunction

  function automatic logic [W+2*NP+1:0] expv();
    return {cur_exp.rgb, cur_exp.disp, cur_exp.pulse, exp_frame, exp_tick};
  endfunction

  function automatic stim_t mk(input logic en, input logic [L-1:0] a, input logic vs);
    stim_t s;
    s.en  = en;
    s.a   = a;
    s.rgb = (L*W)'({$urandom(), $urandom()});
    s.vs  = vs;
    return s;
  endfunction

  task automatic reset_model();
    sb.delete();
    cur_exp   = '0;
    m_vq      = 1'b1;
    m_acc     = '0;
    exp_frame = '0;
    exp_tick  = 1'b0;
  endtask

  task automatic set_idle();
    en_i          = 1'b0;
    v_sync_i      = 1'b1;
    layer_rgb_i   = '0;
    layer_alpha_i = '0;
  endtask

  // One pixel: advance the frame model across the clock edge, apply the new
  // inputs, queue their expected outputs, then stop on the falling edge.
  task automatic drive(input stim_t s);
    logic bdy;
    @(posedge clk_vga);
    bdy = m_vq & ~v_sync_i;
    exp_tick = bdy;
    if (bdy) begin
      exp_frame = m_acc | cur_exp.pulse;
      m_acc     = '0;
    end else begin
      m_acc = m_acc | cur_exp.pulse;
    end
    m_vq = v_sync_i;
    #1;
    en_i          = s.en;
    layer_alpha_i = s.a;
    layer_rgb_i   = s.rgb;
    v_sync_i      = s.vs;
    sb.push_back(model(s.en, s.a, s.rgb));
    if (sb.size() > 2) cur_exp = sb.pop_front();
    else               cur_exp = '0;
    @(negedge clk_vga);
  endtask

  task automatic test_reset();
    stim_t st[$];
    set_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    nvec++;
    if (obs() !== '0) begin
      nerr++;
      $display("FAIL reset_init: got %h want 0", obs());
    end
    repeat (2) @(posedge clk_vga);
    #1;
    nvec++;
    if (obs() !== '0) begin
      nerr++;
      $display("FAIL reset_held: got %h want 0", obs());
    end
    @(negedge clk_vga) rst = 1'b1;
    reset_model();
    repeat (5) st.push_back(mk(1'b1, 3'b000, 1'b1));
    repeat (4) st.push_back(mk(1'b1, 3'b111, 1'b1));
    repeat (2) st.push_back(mk(1'b1, 3'b111, 1'b0));
    repeat (3) st.push_back(mk(1'b1, 3'b111, 1'b1));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL reset_refill step %0d: got %h want %h", i, obs(), expv());
      end
    end
    #2 rst = 1'b0;
    #1;
    nvec++;
    if (obs() !== '0) begin
      nerr++;
      $display("FAIL reset_async: got %h want 0", obs());
    end
`ifdef DISP_MIXER_HIT_CNT_EN
    nvec++;
    if (hit_cnt_o !== '0) begin
      nerr++;
      $display("FAIL reset_hit: got %h want 0", hit_cnt_o);
    end
`endif
    set_idle();
    @(negedge clk_vga) rst = 1'b1;
    reset_model();
  endtask

  task automatic test_priority();
    stim_t st[$];
    st.push_back('{1'b1, 3'b110, {12'hF00, 12'h0F0, 12'h00F}, 1'b1});
    st.push_back('{1'b0, 3'b110, {12'hF00, 12'h0F0, 12'h00F}, 1'b1});
    st.push_back(mk(1'b1, 3'b001, 1'b1));
    st.push_back(mk(1'b1, 3'b100, 1'b1));
    st.push_back(mk(1'b1, 3'b111, 1'b1));
    st.push_back(mk(1'b1, 3'b000, 1'b1));
    repeat (3) st.push_back(mk(1'b0, 3'b000, 1'b1));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL priority step %0d: got %h want %h", i, obs(), expv());
      end
      if (i == 2) begin
        nvec++;
        if (vga_rgb_o !== 12'h0F0 || disp_o !== 1'b1) begin
          nerr++;
          $display("FAIL priority_layer1: got %h/%b want 0f0/1", vga_rgb_o, disp_o);
        end
      end
      if (i == 3) begin
        nvec++;
        if (vga_rgb_o !== 12'h000 || disp_o !== 1'b0) begin
          nerr++;
          $display("FAIL priority_blank: got %h/%b want 000/0", vga_rgb_o, disp_o);
        end
      end
    end
  endtask

  task automatic test_collision();
    stim_t         st[$];
    int            pc;
    logic [NP-1:0] pv;
    pc = 0;
    pv = '0;
    st.push_back(mk(1'b1, 3'b000, 1'b1));
    st.push_back(mk(1'b1, 3'b101, 1'b1));
    repeat (4) st.push_back(mk(1'b1, 3'b000, 1'b1));
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL collision step %0d: got %h want %h", i, obs(), expv());
      end
      if (crash_pulse_o != '0) begin
        pc++;
        pv = crash_pulse_o;
      end
    end
    nvec++;
    if (pc != 1 || pv !== 3'b010) begin
      nerr++;
      $display("FAIL collision_pulse: got %0d cycles of %b want 1 of 010", pc, pv);
    end
  endtask

  task automatic test_frame_latch();
    stim_t         st[$];
    int            ticks;
    logic [NP-1:0] fr;
    // boundary first so the accumulator starts the measured frame empty
    repeat (2) st.push_back(mk(1'b1, 3'b000, 1'b0));
    repeat (4) st.push_back(mk(1'b1, 3'b000, 1'b1));
    st.push_back(mk(1'b1, 3'b011, 1'b1));
    st.push_back(mk(1'b1, 3'b000, 1'b1));
    st.push_back(mk(1'b1, 3'b110, 1'b1));
    repeat (4) st.push_back(mk(1'b1, 3'b000, 1'b1));
    repeat (6) st.push_back(mk(1'b1, 3'b000, 1'b0));
    repeat (3) st.push_back(mk(1'b1, 3'b000, 1'b1));
    ticks = 0;
    fr = 'x;
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL frame_latch step %0d: got %h want %h", i, obs(), expv());
      end
      if (i >= 6 && frame_tick_o) begin
        ticks++;
        fr = crash_frame_o;
      end
    end
    nvec++;
    if (ticks != 1 || fr !== 3'b101) begin
      nerr++;
      $display("FAIL frame_latch_101: got %0d ticks frame %b want 1 tick frame 101", ticks, fr);
    end
    st.delete();
    repeat (8) st.push_back(mk(1'b1, 3'b001, 1'b1));
    repeat (3) st.push_back(mk(1'b0, 3'b000, 1'b0));
    repeat (3) st.push_back(mk(1'b0, 3'b000, 1'b1));
    ticks = 0;
    fr = 'x;
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL frame_clear step %0d: got %h want %h", i, obs(), expv());
      end
      if (frame_tick_o) begin
        ticks++;
        fr = crash_frame_o;
      end
    end
    nvec++;
    if (ticks != 1 || fr !== 3'b000) begin
      nerr++;
      $display("FAIL frame_latch_000: got %0d ticks frame %b want 1 tick frame 000", ticks, fr);
    end
  endtask

  task automatic test_boundary();
    stim_t         st[$];
    int            ticks;
    logic [NP-1:0] fr;
    // the 101 pixel reaches crash_pulse_o on the very cycle v_sync falls
    repeat (4) st.push_back(mk(1'b1, 3'b000, 1'b1));
    st.push_back(mk(1'b1, 3'b101, 1'b1));
    st.push_back(mk(1'b1, 3'b000, 1'b1));
    repeat (3) st.push_back(mk(1'b1, 3'b000, 1'b0));
    repeat (6) st.push_back(mk(1'b1, 3'b000, 1'b1));
    ticks = 0;
    fr = 'x;
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL boundary step %0d: got %h want %h", i, obs(), expv());
      end
      if (frame_tick_o) begin
        ticks++;
        fr = crash_frame_o;
      end
    end
    nvec++;
    if (ticks != 1 || fr !== 3'b010) begin
      nerr++;
      $display("FAIL boundary_close: got %0d ticks frame %b want 1 tick frame 010", ticks, fr);
    end
    st.delete();
    repeat (3) st.push_back(mk(1'b1, 3'b000, 1'b0));
    repeat (3) st.push_back(mk(1'b1, 3'b000, 1'b1));
    ticks = 0;
    fr = 'x;
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL boundary_next step %0d: got %h want %h", i, obs(), expv());
      end
      if (frame_tick_o) begin
        ticks++;
        fr = crash_frame_o;
      end
    end
    nvec++;
    if (ticks != 1 || fr !== 3'b000) begin
      nerr++;
      $display("FAIL boundary_next_frame: got %0d ticks frame %b want 1 tick frame 000", ticks, fr);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 240; i++) begin
      s = mk(($urandom_range(0, 4) != 0), L'($urandom_range(0, 7)), ((i % 40) < 37));
      drive(s);
      nvec++;
      if (obs() !== expv()) begin
        nerr++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, obs(), expv());
      end
    end
  endtask

`ifdef DISP_MIXER_HIT_CNT_EN
  task automatic test_hit_cnt();
    stim_t     st[$];
    int        ticks;
    logic [NP*8-1:0] hv;
    int        npix [2];
    logic [7:0] want [2];
    npix[0] = 300; want[0] = 8'hFF;
    npix[1] = 5;   want[1] = 8'h05;
    for (int r = 0; r < 2; r++) begin
      st.delete();
      repeat (2) st.push_back(mk(1'b1, 3'b000, 1'b0));
      repeat (2) st.push_back(mk(1'b1, 3'b000, 1'b1));
      repeat (npix[r]) st.push_back(mk(1'b1, 3'b011, 1'b1));
      repeat (3) st.push_back(mk(1'b1, 3'b000, 1'b1));
      repeat (2) st.push_back(mk(1'b1, 3'b000, 1'b0));
      repeat (3) st.push_back(mk(1'b1, 3'b000, 1'b1));
      ticks = 0;
      hv = 'x;
      for (int i = 0; i < st.size(); i++) begin
        drive(st[i]);
        nvec++;
        if (obs() !== expv()) begin
          nerr++;
          $display("FAIL hit_cnt_run%0d step %0d: got %h want %h", r, i, obs(), expv());
        end
        if (i >= 4 && frame_tick_o) begin
          ticks++;
          hv = hit_cnt_o;
        end
      end
      nvec++;
      if (ticks != 1 || hv !== {16'h0000, want[r]}) begin
        nerr++;
        $display("FAIL hit_cnt_%0dpix: got %0d ticks count %h want 1 tick count %h",
                 npix[r], ticks, hv, {16'h0000, want[r]});
      end
    end
  endtask
`endif

  initial begin
    set_idle();
    rst = 1'b1;
    reset_model();
    test_reset();
    test_priority();
    test_collision();
    test_frame_latch();
    test_boundary();
    test_back_to_back();
`ifdef DISP_MIXER_HIT_CNT_EN
    test_hit_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
